// File: rtl/game_pkg.sv
// Shared state encoding and default sizing for the flag-collecting game controller.
package game_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_DYING,
        S_CLEAR,
        S_WIN,
        S_OVER
    } state_t;

    localparam int DEF_NUM_FLAGS    = 5;
    localparam int DEF_MAX_LIVES    = 3;
    localparam int DEF_NUM_LEVELS   = 3;
    localparam int DEF_PAUSE_FRAMES = 120;
endpackage

// File: rtl/game_controller_if.sv
// Game I/O bundle: play-field events into the controller, status out to the sprite and colour logic.
interface game_controller_if #(
    parameter int NUM_FLAGS = game_pkg::DEF_NUM_FLAGS
);
    localparam int CNT_W = $clog2(NUM_FLAGS + 1);

    logic                 frame_tick;
    logic                 start;
    logic                 crash_on;
    logic [NUM_FLAGS-1:0] flagBurst;
    logic [NUM_FLAGS-1:0] flagDisplay;
    logic [CNT_W-1:0]     flagcount;
    logic [2:0]           livesCount;
    logic [1:0]           levelindex;
    logic                 flagreset;
    logic                 freeze;
    logic                 Winscreen;
    logic                 GameOver;

    modport slave (
        input  frame_tick, start, crash_on, flagBurst,
        output flagDisplay, flagcount, livesCount, levelindex,
        output flagreset, freeze, Winscreen, GameOver
    );

    modport master (
        output frame_tick, start, crash_on, flagBurst,
        input  flagDisplay, flagcount, livesCount, levelindex,
        input  flagreset, freeze, Winscreen, GameOver
    );
endinterface

// File: rtl/game_controller_popcount.sv
// Combinational population count of a bit vector.
module popcount #(
    parameter int WIDTH = 5,
    parameter int CNT_W = $clog2(WIDTH + 1)
)(
    input  logic [WIDTH-1:0] i_bits,
    output logic [CNT_W-1:0] o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_bits[i]);
        end
    end
endmodule

// File: rtl/game_controller.sv
// Game flow controller: lives, levels, flag collection and the timed death/clear pauses.
module game_controller
    import game_pkg::*;
#(
    parameter int NUM_FLAGS    = DEF_NUM_FLAGS,
    parameter int MAX_LIVES    = DEF_MAX_LIVES,
    parameter int NUM_LEVELS   = DEF_NUM_LEVELS,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
)(
    input  logic             Clk,
    input  logic             Reset,
    game_controller_if.slave bus
);
    localparam int               CNT_W      = $clog2(NUM_FLAGS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(NUM_FLAGS);
    localparam logic [2:0]       LIVES_INIT = 3'(MAX_LIVES);
    localparam logic [1:0]       LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [7:0]       PAUSE_END  = 8'(PAUSE_FRAMES);

    state_t               r_state, w_state_nx;
    logic [NUM_FLAGS-1:0] r_flags, w_flags_nx, w_new;
    logic [CNT_W-1:0]     r_count, w_count_nx, w_new_cnt, w_count_add;
    logic [2:0]           r_lives, w_lives_nx;
    logic [1:0]           r_level, w_level_nx;
    logic [7:0]           r_pause, w_pause_nx, w_pause_inc;
    logic                 w_pause_end, w_flagreset_nx;
    logic                 r_flagreset, r_freeze, r_win, r_over;

    // Only flags still on screen can be collected; already-cleared bits are masked off.
    assign w_new = bus.flagBurst & r_flags;

    popcount #(.WIDTH(NUM_FLAGS), .CNT_W(CNT_W)) u_popcount (
        .i_bits  (w_new),
        .o_count (w_new_cnt)
    );

    assign w_count_add = r_count + w_new_cnt;
    assign w_pause_inc = r_pause + 8'd1;
    assign w_pause_end = bus.frame_tick && (w_pause_inc == PAUSE_END);

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx     = r_state;
        w_flags_nx     = r_flags;
        w_count_nx     = r_count;
        w_lives_nx     = r_lives;
        w_level_nx     = r_level;
        w_pause_nx     = r_pause;
        w_flagreset_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx     = S_PLAY;
                    w_lives_nx     = LIVES_INIT;
                    w_level_nx     = 2'd0;
                    w_flags_nx     = '1;
                    w_count_nx     = '0;
                    w_flagreset_nx = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.crash_on) begin
                    w_state_nx = S_DYING;
                    w_lives_nx = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
                    w_pause_nx = 8'd0;
                end else begin
                    w_flags_nx = r_flags & ~w_new;
                    w_count_nx = w_count_add;
                    if (w_count_add == FULL_CNT) begin
                        w_state_nx = S_CLEAR;
                        w_pause_nx = 8'd0;
                    end
                end
            end
            S_DYING: begin
                if (bus.frame_tick) w_pause_nx = w_pause_inc;
                if (w_pause_end) w_state_nx = (r_lives == 3'd0) ? S_OVER : S_PLAY;
            end
            S_CLEAR: begin
                if (bus.frame_tick) w_pause_nx = w_pause_inc;
                if (w_pause_end) begin
                    if (r_level >= LAST_LEVEL) begin
                        w_state_nx = S_WIN;
                    end else begin
                        w_state_nx     = S_PLAY;
                        w_level_nx     = r_level + 2'd1;
                        w_flags_nx     = '1;
                        w_count_nx     = '0;
                        w_flagreset_nx = 1'b1;
                    end
                end
            end
            S_WIN, S_OVER: begin
                if (bus.start) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status flags are derived from the next state so they line up with r_state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flags     <= '1;
            r_count     <= '0;
            r_lives     <= LIVES_INIT;
            r_level     <= 2'd0;
            r_pause     <= 8'd0;
            r_flagreset <= 1'b0;
            r_freeze    <= 1'b1;
            r_win       <= 1'b0;
            r_over      <= 1'b0;
        end else begin
            r_flags     <= w_flags_nx;
            r_count     <= w_count_nx;
            r_lives     <= w_lives_nx;
            r_level     <= w_level_nx;
            r_pause     <= w_pause_nx;
            r_flagreset <= w_flagreset_nx;
            r_freeze    <= (w_state_nx != S_PLAY);
            r_win       <= (w_state_nx == S_WIN);
            r_over      <= (w_state_nx == S_OVER);
        end
    end

    assign bus.flagDisplay = r_flags;
    assign bus.flagcount   = r_count;
    assign bus.livesCount  = r_lives;
    assign bus.levelindex  = r_level;
    assign bus.flagreset   = r_flagreset;
    assign bus.freeze      = r_freeze;
    assign bus.Winscreen   = r_win;
    assign bus.GameOver    = r_over;
endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios with literal expectations, then random play against a behavioural model.
module tb_game_controller;
    localparam int NF = 5;
    localparam int ML = 3;
    localparam int NL = 3;
    localparam int PF = 120;

    localparam int P_IDLE  = 0;
    localparam int P_PLAY  = 1;
    localparam int P_DYING = 2;
    localparam int P_CLEAR = 3;
    localparam int P_WIN   = 4;
    localparam int P_OVER  = 5;

    logic Clk = 1'b0;
    logic Reset;

    game_controller_if #(.NUM_FLAGS(NF)) bus ();

    game_controller #(
        .NUM_FLAGS(NF), .MAX_LIVES(ML), .NUM_LEVELS(NL), .PAUSE_FRAMES(PF)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial forever #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    // Behavioural model of the game rules.
    int          m_ph    = P_IDLE;
    int          m_lives = ML;
    int          m_level = 0;
    int          m_cnt   = 0;
    int          m_pause = 0;
    logic [NF-1:0] m_disp = '1;
    logic [NF-1:0] m_got;
    bit          m_fr    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            m_ph = P_IDLE; m_lives = ML; m_level = 0; m_cnt = 0;
            m_disp = '1; m_fr = 1'b0; m_pause = 0;
        end else begin
            m_fr = 1'b0;
            case (m_ph)
                P_IDLE: if (bus.start) begin
                    m_ph = P_PLAY; m_lives = ML; m_level = 0;
                    m_disp = '1; m_cnt = 0; m_fr = 1'b1;
                end
                P_PLAY: begin
                    if (bus.crash_on) begin
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        m_ph = P_DYING; m_pause = 0;
                    end else begin
                        m_got  = bus.flagBurst & m_disp;
                        m_cnt  = m_cnt + $countones(m_got);
                        m_disp = m_disp & ~m_got;
                        if (m_cnt == NF) begin m_ph = P_CLEAR; m_pause = 0; end
                    end
                end
                P_DYING: if (bus.frame_tick) begin
                    m_pause++;
                    if (m_pause == PF) m_ph = (m_lives == 0) ? P_OVER : P_PLAY;
                end
                P_CLEAR: if (bus.frame_tick) begin
                    m_pause++;
                    if (m_pause == PF) begin
                        if (m_level == NL - 1) m_ph = P_WIN;
                        else begin
                            m_level++; m_disp = '1; m_cnt = 0; m_fr = 1'b1; m_ph = P_PLAY;
                        end
                    end
                end
                default: if (bus.start) m_ph = P_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("m_flagDisplay", bus.flagDisplay, m_disp);
            chk("m_flagcount",   bus.flagcount,   m_cnt);
            chk("m_livesCount",  bus.livesCount,  m_lives);
            chk("m_levelindex",  bus.levelindex,  m_level);
            chk("m_flagreset",   bus.flagreset,   m_fr);
            chk("m_freeze",      bus.freeze,      m_ph != P_PLAY);
            chk("m_Winscreen",   bus.Winscreen,   m_ph == P_WIN);
            chk("m_GameOver",    bus.GameOver,    m_ph == P_OVER);
        end
    end

    task automatic pause_ticks(input int n);
        repeat (n) begin
            bus.frame_tick = 1'b1; step();
            bus.frame_tick = 1'b0; step();
        end
    endtask

    task automatic clear_level();
        bus.flagBurst = '1; step(); bus.flagBurst = '0;
        pause_ticks(PF);
    endtask

    task automatic crash_pause(input int exp_lives);
        bus.crash_on = 1'b1; step(); bus.crash_on = 1'b0;
        chk("crash_lives", bus.livesCount, exp_lives);
        pause_ticks(PF);
    endtask

    initial begin
        Reset = 1'b1;
        bus.start = 1'b0; bus.crash_on = 1'b0; bus.frame_tick = 1'b0; bus.flagBurst = '0;
        step(); step();
        cmp_en = 1'b1;
        chk("rst_lives",  bus.livesCount, 3);
        chk("rst_level",  bus.levelindex, 0);
        chk("rst_count",  bus.flagcount, 0);
        chk("rst_disp",   bus.flagDisplay, 5'b11111);
        chk("rst_freeze", bus.freeze, 1);
        chk("rst_over",   bus.GameOver, 0);
        chk("rst_win",    bus.Winscreen, 0);
        chk("rst_fr",     bus.flagreset, 0);
        Reset = 1'b0; step();

        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("start_fr",     bus.flagreset, 1);
        chk("start_freeze", bus.freeze, 0);

        bus.flagBurst = 5'b00001; repeat (3) step(); bus.flagBurst = '0;
        chk("one_count", bus.flagcount, 1);
        chk("one_disp",  bus.flagDisplay, 5'b11110);

        bus.flagBurst = 5'b10110; step(); bus.flagBurst = '0;
        chk("multi_count", bus.flagcount, 4);
        chk("multi_disp",  bus.flagDisplay, 5'b01000);

        bus.flagBurst = 5'b01000; bus.crash_on = 1'b1; step();
        bus.flagBurst = '0; bus.crash_on = 1'b0;
        chk("prio_lives",  bus.livesCount, 2);
        chk("prio_count",  bus.flagcount, 4);
        chk("prio_disp",   bus.flagDisplay, 5'b01000);
        chk("prio_freeze", bus.freeze, 1);
        pause_ticks(PF);
        chk("revive_freeze", bus.freeze, 0);
        chk("revive_count",  bus.flagcount, 4);

        bus.flagBurst = 5'b01000; step(); bus.flagBurst = '0;
        chk("clear_count",  bus.flagcount, 5);
        chk("clear_freeze", bus.freeze, 1);
        pause_ticks(PF - 1);
        chk("clear_119_level", bus.levelindex, 0);
        bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
        chk("clear_level", bus.levelindex, 1);
        chk("clear_fr",    bus.flagreset, 1);
        chk("clear_disp",  bus.flagDisplay, 5'b11111);
        chk("clear_cnt0",  bus.flagcount, 0);
        step();
        chk("clear_fr_end", bus.flagreset, 0);

        crash_pause(1);
        crash_pause(0);
        chk("over1", bus.GameOver, 1);
        bus.start = 1'b1; step(); bus.start = 1'b0; step();

        bus.start = 1'b1; step(); bus.start = 1'b0;
        crash_pause(2);
        crash_pause(1);
        crash_pause(0);
        chk("over2", bus.GameOver, 1);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("over_idle",   bus.GameOver, 0);
        chk("over_freeze", bus.freeze, 1);

        bus.start = 1'b1; step(); bus.start = 1'b0;
        clear_level();
        clear_level();
        chk("lvl2", bus.levelindex, 2);
        bus.flagBurst = '1; step(); bus.flagBurst = '0;
        pause_ticks(60);
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("midrst_level", bus.levelindex, 0);
        chk("midrst_lives", bus.livesCount, 3);
        chk("midrst_win",   bus.Winscreen, 0);
        step();

        bus.start = 1'b1; step(); bus.start = 1'b0;
        clear_level();
        clear_level();
        clear_level();
        chk("win",       bus.Winscreen, 1);
        chk("win_level", bus.levelindex, 2);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("win_idle", bus.Winscreen, 0);

        repeat (8000) begin
            Reset          = ($urandom_range(0, 999) == 0);
            bus.start      = ($urandom_range(0, 15) == 0);
            bus.crash_on   = ($urandom_range(0, 39) == 0);
            bus.frame_tick = 1'($urandom_range(0, 1));
            bus.flagBurst  = 5'($urandom) & 5'($urandom) & 5'($urandom);
            step();
        end
        Reset = 1'b0; bus.start = 1'b0; bus.crash_on = 1'b0;
        bus.frame_tick = 1'b0; bus.flagBurst = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
